// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StStall
  } arb_state_e;

  localparam int unsigned FifoDepth = 16;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit scanning last+1 .. last+NREQ (mod NREQ).
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            any,
  output logic [IDW-1:0]  idx
);

  always_comb begin
    int unsigned j;
    j   = 0;
    any = 1'b0;
    idx = '0;
    // Walk from the farthest candidate down so the nearest one after last wins.
    for (int unsigned k = NREQ; k >= 1; k--) begin
      j = (32'(last) + k) % NREQ;
      if (req[j]) begin
        any = 1'b1;
        idx = j[IDW-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NREQ valid/ready producers.
// Optional multi-beat grants are enabled by defining ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int unsigned NREQ      = 4,
  parameter int unsigned DW        = 8,
  parameter int unsigned BURST_LEN = 4,
  localparam int unsigned IDW      = $clog2(NREQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DW-1:0]   req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 fifo_full,
  output logic                 fifo_wr,
  output logic [DW-1:0]        fifo_wdata,
  output logic [IDW-1:0]       gnt_id,
  output logic                 busy
);

  if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1) begin : g_param_check
    $error("fifo_wr_arbiter: unsupported NREQ or BURST_LEN");
  end

  arb_state_e     state_q, state_d;
  logic [IDW-1:0] owner_q, owner_d;
  logic [IDW-1:0] last_q, last_d;
  logic [IDW-1:0] pick_last, pick_idx;
  logic           pick_any;
  logic           own_valid, xfer, rotate, in_own;

  assign in_own    = (state_q == StOwn);
  assign own_valid = req_valid[owner_q];
  assign xfer      = in_own & own_valid & ~fifo_full;
  // While owning, the next owner is searched as if the current owner had just been served.
  assign pick_last = in_own ? owner_q : last_q;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req  (req_valid),
    .last (pick_last),
    .any  (pick_any),
    .idx  (pick_idx)
  );

`ifdef ARB_BURST_EN
  localparam int unsigned CntW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;

  assign rotate = in_own & (~own_valid | (xfer & (burst_cnt_q == CntW'(BURST_LEN - 1))));

  always_comb begin
    burst_cnt_d = burst_cnt_q;
    if (rotate) begin
      burst_cnt_d = '0;
    end else if (xfer) begin
      burst_cnt_d = burst_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt_q <= '0;
    end else begin
      burst_cnt_q <= burst_cnt_d;
    end
  end
`else
  assign rotate = in_own & (~own_valid | xfer);
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          owner_d = pick_idx;
          state_d = StOwn;
        end
      end
      StOwn: begin
        if (rotate) begin
          last_d = owner_q;
          if (pick_any) begin
            owner_d = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end else if (own_valid && fifo_full) begin
          state_d = StStall;
        end
      end
      StStall: begin
        if (!fifo_full) begin
          state_d = StOwn;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= IDW'(NREQ - 1);
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
    end
  end

  // Outputs are forced low while rst is high so a pending beat is dropped in the reset cycle.
  always_comb begin
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = '0;
    busy       = 1'b0;
    gnt_id     = '0;
    if (!rst) begin
      busy    = (state_q != StIdle);
      fifo_wr = xfer;
      if (busy) begin
        gnt_id = owner_q;
      end
      if (in_own) begin
        fifo_wdata = req_data[owner_q*DW +: DW];
      end
      if (xfer) begin
        req_ready = NREQ'(1) << owner_q;
      end
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (NREQ=4, DW=8); honours ARB_BURST_EN.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        fifo_full;
  logic        fifo_wr;
  logic [7:0]  fifo_wdata;
  logic [1:0]  gnt_id;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic ovf_seen = 1'b0;

  int exp3 [6];
  int exp5 [10];

  fifo_wr_arbiter #(
    .NREQ      (4),
    .DW        (8),
    .BURST_LEN (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .gnt_id     (gnt_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // A write into a full FIFO would set its overflow flag.
  always @(negedge clk) begin
    if (fifo_wr && fifo_full) ovf_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic set_data(input int id, input logic [7:0] val);
    req_data[id*8 +: 8] = val;
  endtask

  task automatic expect_quiet(input string tag, input logic exp_busy);
    check({tag, ".wr"}, 32'(fifo_wr), 32'(0));
    check({tag, ".ready"}, 32'(req_ready), 32'(0));
    check({tag, ".busy"}, 32'(busy), 32'(exp_busy));
  endtask

  task automatic expect_beat(input string tag, input int id, input logic [7:0] d);
    check({tag, ".wr"}, 32'(fifo_wr), 32'(1));
    check({tag, ".wdata"}, 32'(fifo_wdata), 32'(d));
    check({tag, ".ready"}, 32'(req_ready), 32'(1) << id);
    check({tag, ".gnt"}, 32'(gnt_id), 32'(id));
  endtask

  initial begin
`ifdef ARB_BURST_EN
    exp3 = '{3, 3, 3, 3, 0, 0};
    exp5 = '{3, 3, 3, 3, 0, 0, 0, 0, 3, 3};
`else
    exp3 = '{3, 0, 1, 2, 3, 0};
    exp5 = '{3, 0, 3, 0, 3, 0, 3, 0, 3, 0};
`endif

    // Reset held two cycles with every requester valid.
    rst       = 1'b1;
    req_valid = 4'hF;
    req_data  = 32'h1312_1110;
    fifo_full = 1'b0;
    sample();
    expect_quiet("rst_c1", 1'b0);
    check("rst_c1.gnt", 32'(gnt_id), 32'(0));
    tick();
    sample();
    expect_quiet("rst_c2", 1'b0);
    check("rst_c2.gnt", 32'(gnt_id), 32'(0));
    tick();
    rst       = 1'b0;
    req_valid = 4'h0;
    sample();
    expect_quiet("post_rst", 1'b0);

    // Single requester 2, three beats; one idle cycle of grant latency.
    tick();
    req_valid = 4'b0100;
    set_data(2, 8'hA1);
    sample();
    expect_quiet("single.lat", 1'b0);
    tick();
    sample();
    expect_beat("single.b1", 2, 8'hA1);
    tick();
    set_data(2, 8'hA2);
    sample();
    expect_beat("single.b2", 2, 8'hA2);
    tick();
    set_data(2, 8'hA3);
    sample();
    expect_beat("single.b3", 2, 8'hA3);
    tick();
    req_valid = 4'h0;
    sample();
    expect_quiet("single.rel", 1'b1);
    tick();
    sample();
    expect_quiet("single.idle", 1'b0);

    // All four valid: back-to-back writes, order starts after last owner (2).
    req_data = 32'h1312_1110;
    tick();
    req_valid = 4'hF;
    sample();
    expect_quiet("all.lat", 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      sample();
      expect_beat($sformatf("all.b%0d", i), exp3[i], 8'(8'h10 + exp3[i]));
    end
    tick();
    req_valid = 4'h0;
    sample();
    expect_quiet("all.rel", 1'b1);
    tick();
    sample();
    expect_quiet("all.idle", 1'b0);

    // FIFO full for 5 cycles while owner 1 is valid.
    set_data(1, 8'h5A);
    tick();
    req_valid = 4'b0010;
    sample();
    expect_quiet("stall.lat", 1'b0);
    tick();
    fifo_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      sample();
      expect_quiet($sformatf("stall.f%0d", i), 1'b1);
      check($sformatf("stall.f%0d.gnt", i), 32'(gnt_id), 32'(1));
      if (i < 4) tick();
    end
    tick();
    fifo_full = 1'b0;
    sample();
    expect_quiet("stall.drop", 1'b1);
    tick();
    sample();
    expect_beat("stall.resume", 1, 8'h5A);
    tick();
    req_valid = 4'h0;
    sample();
    expect_quiet("stall.rel", 1'b1);
    tick();
    sample();
    expect_quiet("stall.idle", 1'b0);

    // Requesters 0 and 3; alternation granularity depends on burst mode.
    req_data = 32'h3300_00C0;
    tick();
    req_valid = 4'b1001;
    sample();
    expect_quiet("pair.lat", 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      sample();
      expect_beat($sformatf("pair.b%0d", i), exp5[i], (exp5[i] == 3) ? 8'h33 : 8'hC0);
    end
    tick();
    req_valid = 4'h0;
    sample();
    expect_quiet("pair.rel", 1'b1);
    tick();
    sample();
    expect_quiet("pair.idle", 1'b0);

    // Reset while owner 2 is mid-burst; afterwards first grant goes to 0.
    req_data = 32'h00E2_00E0;
    tick();
    req_valid = 4'b0100;
    sample();
    expect_quiet("mid.lat", 1'b0);
    tick();
    sample();
    expect_beat("mid.b1", 2, 8'hE2);
    tick();
    sample();
    expect_beat("mid.b2", 2, 8'hE2);
    tick();
    rst = 1'b1;
    sample();
    expect_quiet("mid.rst", 1'b0);
    check("mid.rst.gnt", 32'(gnt_id), 32'(0));
    tick();
    rst       = 1'b0;
    req_valid = 4'b0101;
    sample();
    expect_quiet("mid.lat2", 1'b0);
    tick();
    sample();
    expect_beat("mid.first", 0, 8'hE0);
    tick();
    req_valid = 4'h0;
    tick();
    tick();

    check("no_write_when_full", 32'(ovf_seen), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
